// File: rtl/credit_manager_vc.sv
// Per-(port, VC) saturating credit tracker with send gating, registered credit
// return, counter readback and optional sticky error flags (CM_ERR_CHECK_EN).
module credit_manager_vc #(
  parameter  int unsigned NUM_PORTS  = 5,
  parameter  int unsigned NUM_VCS    = 2,
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned LOW_WM     = 2,
  localparam int unsigned N          = NUM_PORTS * NUM_VCS,
  localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned SEL_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        downstream_credit,
  input  logic [N-1:0]        outq_credit_return,
  input  logic                cfg_init,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [N-1:0]        can_send,
  output logic [N-1:0]        credit_low,
  output logic [N-1:0]        upstream_credit,
  output logic [CREDIT_W-1:0] rd_count,
  output logic [N-1:0]        err_underflow,
  output logic [N-1:0]        err_overflow
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(FIFO_DEPTH);
  localparam logic [CREDIT_W-1:0] LOW  = CREDIT_W'(LOW_WM);

  logic [CREDIT_W-1:0] count     [N];
  logic [CREDIT_W-1:0] count_nxt [N];
`ifdef CM_ERR_CHECK_EN
  logic [N-1:0] uf_set;
  logic [N-1:0] of_set;
`endif

  // Next-count: init > simultaneous hold > consume > return, saturating at both ends
  always_comb begin
    count_nxt = count;
`ifdef CM_ERR_CHECK_EN
    uf_set = '0;
    of_set = '0;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (cfg_init) begin
        count_nxt[i] = FULL;
      end else if (downstream_credit[i] && !outq_credit_return[i]) begin
        if (count[i] != '0) begin
          count_nxt[i] = count[i] - CREDIT_W'(1);
        end else begin
`ifdef CM_ERR_CHECK_EN
          uf_set[i] = 1'b1;
`endif
        end
      end else if (outq_credit_return[i] && !downstream_credit[i]) begin
        if (count[i] != FULL) begin
          count_nxt[i] = count[i] + CREDIT_W'(1);
        end else begin
`ifdef CM_ERR_CHECK_EN
          of_set[i] = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        count[i] <= FULL;
      end
      upstream_credit <= '0;
      rd_count        <= '0;
    end else begin
      count           <= count_nxt;
      upstream_credit <= outq_credit_return;
      // Readback samples the pre-update value; out-of-range selects read as zero
      if (32'(rd_sel) < N) begin
        rd_count <= count[rd_sel];
      end else begin
        rd_count <= '0;
      end
    end
  end

  // Send gating decodes only from registered counters
  always_comb begin
    can_send   = '0;
    credit_low = '0;
    for (int unsigned i = 0; i < N; i++) begin
      can_send[i]   = (count[i] != '0);
      credit_low[i] = (count[i] <= LOW);
    end
  end

`ifdef CM_ERR_CHECK_EN
  // Sticky protocol errors; cfg_init clears and wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= '0;
      err_overflow  <= '0;
    end else if (cfg_init) begin
      err_underflow <= '0;
      err_overflow  <= '0;
    end else begin
      err_underflow <= err_underflow | uf_set;
      err_overflow  <= err_overflow | of_set;
    end
  end
`else
  assign err_underflow = '0;
  assign err_overflow  = '0;
`endif

endmodule

// File: tb/tb_credit_manager_vc.sv
// Directed and shadow-model stress bench for credit_manager_vc.
module tb_credit_manager_vc;

  localparam int N = 10;
  localparam int DEPTH = 8;
  localparam int LWM = 2;
`ifdef CM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] dn;
  logic [N-1:0] ret;
  logic         cfg_init;
  logic [3:0]   rd_sel;
  logic [N-1:0] can_send;
  logic [N-1:0] credit_low;
  logic [N-1:0] upstream_credit;
  logic [3:0]   rd_count;
  logic [N-1:0] err_underflow;
  logic [N-1:0] err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  credit_manager_vc dut (
    .clk                (clk),
    .rst                (rst),
    .downstream_credit  (dn),
    .outq_credit_return (ret),
    .cfg_init           (cfg_init),
    .rd_sel             (rd_sel),
    .can_send           (can_send),
    .credit_low         (credit_low),
    .upstream_credit    (upstream_credit),
    .rd_count           (rd_count),
    .err_underflow      (err_underflow),
    .err_overflow       (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dn = '0; ret = '0; cfg_init = 1'b0; rd_sel = '0;
    #1;
    n_checks++;
    if (can_send !== 10'h3FF) begin n_fail++; $display("FAIL reset_can_send: got %h want 3ff", can_send); end
    n_checks++;
    if (credit_low !== 10'h000) begin n_fail++; $display("FAIL reset_credit_low: got %h want 000", credit_low); end
    n_checks++;
    if (upstream_credit !== 10'h000 || rd_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_regs: upstream %h rd_count %0d want 0/0", upstream_credit, rd_count);
    end
    n_checks++;
    if (err_underflow !== 10'h000 || err_overflow !== 10'h000) begin
      n_fail++; $display("FAIL reset_err: uf %h of %h want 0/0", err_underflow, err_overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_consume();
    int exp_cnt;
    rd_sel = 4'd0;
    dn = 10'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_cnt = DEPTH - k;
      n_checks++;
      if (can_send[0] !== (exp_cnt != 0)) begin n_fail++; $display("FAIL consume_can_send edge %0d: got %b want %b", k, can_send[0], exp_cnt != 0); end
      n_checks++;
      if (credit_low[0] !== (exp_cnt <= LWM)) begin n_fail++; $display("FAIL consume_credit_low edge %0d: got %b want %b", k, credit_low[0], exp_cnt <= LWM); end
      n_checks++;
      if (can_send[N-1:1] !== 9'h1FF) begin n_fail++; $display("FAIL consume_others edge %0d: got %h want 1ff", k, can_send[N-1:1]); end
      n_checks++;
      if (rd_count !== 4'(DEPTH - k + 1)) begin n_fail++; $display("FAIL consume_rd_count edge %0d: got %0d want %0d", k, rd_count, DEPTH - k + 1); end
    end
    dn = '0;
    tick();
    n_checks++;
    if (rd_count !== 4'd0) begin n_fail++; $display("FAIL consume_rd_zero: got %0d want 0", rd_count); end
    ret = 10'b1;
    tick();
    ret = '0;
    n_checks++;
    if (can_send[0] !== 1'b1) begin n_fail++; $display("FAIL return_at_zero: can_send[0] got %b want 1", can_send[0]); end
  endtask

  task automatic test_underflow();
    dn = 10'b1000;
    repeat (8) tick();
    ret = 10'b1000;
    tick();
    ret = '0;
    n_checks++;
    if (can_send[3] !== 1'b0 || err_underflow !== 10'h000) begin
      n_fail++; $display("FAIL both_at_zero: can_send[3] %b uf %h want 0/000", can_send[3], err_underflow);
    end
    tick();
    dn = '0;
    n_checks++;
    if (can_send[3] !== 1'b0 || err_underflow !== (10'(ERR_EN) << 3)) begin
      n_fail++; $display("FAIL underflow_set: can_send[3] %b uf %h want 0/%h", can_send[3], err_underflow, 10'(ERR_EN) << 3);
    end
    repeat (2) tick();
    n_checks++;
    if (err_underflow !== (10'(ERR_EN) << 3)) begin n_fail++; $display("FAIL underflow_sticky: got %h want %h", err_underflow, 10'(ERR_EN) << 3); end
    cfg_init = 1'b1; dn = 10'b1000;
    tick();
    cfg_init = 1'b0; dn = '0; rd_sel = 4'd3;
    n_checks++;
    if (err_underflow !== 10'h000 || can_send !== 10'h3FF || credit_low !== 10'h000) begin
      n_fail++; $display("FAIL init_clear: uf %h cs %h cl %h want 000/3ff/000", err_underflow, can_send, credit_low);
    end
    tick();
    n_checks++;
    if (rd_count !== 4'd8) begin n_fail++; $display("FAIL init_count: got %0d want 8", rd_count); end
  endtask

  task automatic test_overflow();
    ret = 10'b100000; rd_sel = 4'd5;
    tick();
    ret = '0;
    n_checks++;
    if (err_overflow !== (10'(ERR_EN) << 5)) begin n_fail++; $display("FAIL overflow_flag: got %h want %h", err_overflow, 10'(ERR_EN) << 5); end
    tick();
    n_checks++;
    if (rd_count !== 4'd8 || can_send[5] !== 1'b1 || credit_low[5] !== 1'b0) begin
      n_fail++; $display("FAIL overflow_hold: rd %0d cs %b cl %b want 8/1/0", rd_count, can_send[5], credit_low[5]);
    end
    cfg_init = 1'b1;
    tick();
    cfg_init = 1'b0;
    n_checks++;
    if (err_overflow !== 10'h000) begin n_fail++; $display("FAIL overflow_clear: got %h want 000", err_overflow); end
  endtask

  task automatic test_upstream();
    logic [N-1:0] pat;
    pat = 10'b1010000101;
    ret = pat; cfg_init = 1'b1;
    tick();
    ret = '0; cfg_init = 1'b0;
    n_checks++;
    if (upstream_credit !== pat) begin n_fail++; $display("FAIL upstream_pulse: got %b want %b", upstream_credit, pat); end
    n_checks++;
    if (err_overflow !== 10'h000) begin n_fail++; $display("FAIL init_wins_err: got %h want 000", err_overflow); end
    tick();
    n_checks++;
    if (upstream_credit !== 10'h000) begin n_fail++; $display("FAIL upstream_clear: got %b want 0", upstream_credit); end
    ret = 10'b10;
    tick();
    n_checks++;
    if (upstream_credit !== 10'b10) begin n_fail++; $display("FAIL back_to_back_1: got %b want 10", upstream_credit); end
    tick();
    ret = '0;
    n_checks++;
    if (upstream_credit !== 10'b10) begin n_fail++; $display("FAIL back_to_back_2: got %b want 10", upstream_credit); end
    tick();
    n_checks++;
    if (upstream_credit !== 10'h000) begin n_fail++; $display("FAIL back_to_back_end: got %b want 0", upstream_credit); end
  endtask

  task automatic test_stress();
    int m [N];
    logic [N-1:0] exp_cs, exp_cl, exp_up, d, r;
    logic [3:0] exp_rd;
    logic c;
    int s;
    for (int i = 0; i < N; i++) m[i] = DEPTH;
    for (int cyc = 0; cyc < 200; cyc++) begin
      d = 10'($urandom);
      r = (cyc < 100) ? 10'($urandom & $urandom) : 10'($urandom);
      c = (cyc == 150);
      s = int'($urandom_range(0, 15));
      dn = d; ret = r; cfg_init = c; rd_sel = 4'(s);
      if (cyc == 100) begin
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (can_send !== 10'h3FF || credit_low !== 10'h000 || upstream_credit !== 10'h000 || rd_count !== 4'd0) begin
          n_fail++; $display("FAIL async_reset: cs %h cl %h up %h rd %0d", can_send, credit_low, upstream_credit, rd_count);
        end
        for (int i = 0; i < N; i++) m[i] = DEPTH;
        #1 rst = 1'b0;
      end
      tick();
      exp_rd = (s < N) ? 4'(m[s]) : 4'd0;
      exp_up = r;
      for (int i = 0; i < N; i++) begin
        if (c) m[i] = DEPTH;
        else if (d[i] && !r[i]) begin if (m[i] > 0) m[i]--; end
        else if (r[i] && !d[i]) begin if (m[i] < DEPTH) m[i]++; end
        exp_cs[i] = (m[i] != 0);
        exp_cl[i] = (m[i] <= LWM);
      end
      n_checks++;
      if (can_send !== exp_cs || credit_low !== exp_cl || rd_count !== exp_rd || upstream_credit !== exp_up) begin
        n_fail++;
        $display("FAIL stress cyc %0d: cs %h/%h cl %h/%h rd %0d/%0d up %h/%h (got/want)",
                 cyc, can_send, exp_cs, credit_low, exp_cl, rd_count, exp_rd, upstream_credit, exp_up);
      end
    end
    dn = '0; ret = '0; cfg_init = 1'b0;
  endtask

  initial begin
    test_reset();
    test_consume();
    test_underflow();
    test_overflow();
    test_upstream();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
